regfile_access_controller: RTL

//  Client-side controller for dual_port_register_file. Drives both read ports
//  and the single write port, fetching two operands per issued op. A 16-entry

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_access_controller_if.sv | 62 ++++++
 rtl/regfile_scoreboard.sv | 50 +++++
 rtl/regfile_access_controller.sv | 98 +++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared sizing and types for the register-file access controller and its scoreboard.
package regfile_pkg;

   localparam int DATA_WIDTH = 16;
   localparam int ADDR_WIDTH = 4;
   localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

   typedef logic [DATA_WIDTH-1:0] reg_data_t;
   typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
   typedef logic [ADDR_WIDTH:0]   reg_count_t;

endpackage

// File: rtl/regfile_access_controller_if.sv
// Issue, operand, writeback and register-file signals of the access controller.
// The slave modport is the controller's view; master is the surrounding pipeline.
interface regfile_access_controller_if;
   import regfile_pkg::*;

   logic       issue_valid;
   logic       issue_ready;
   reg_addr_t  issue_rs1;
   reg_addr_t  issue_rs2;
   reg_addr_t  issue_rd;
   logic       issue_rd_en;

   reg_addr_t  rf_read_address_1;
   reg_addr_t  rf_read_address_2;
   reg_data_t  rf_data_out1;
   reg_data_t  rf_data_out2;
   logic       rf_write_enable;
   reg_addr_t  rf_write_address;
   reg_data_t  rf_data_in;

   logic       op_valid;
   logic       op_ready;
   reg_data_t  op_a;
   reg_data_t  op_b;
   reg_addr_t  op_rd;
   logic       op_rd_en;

   logic       wb_valid;
   logic       wb_ready;
   reg_addr_t  wb_address;
   reg_data_t  wb_data;

   reg_count_t pending_count;
   logic       wb_err;

   modport slave (
      input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_rd_en,
      output issue_ready,
      output rf_read_address_1, rf_read_address_2, rf_write_enable,
      output rf_write_address, rf_data_in,
      input  rf_data_out1, rf_data_out2,
      output op_valid, op_a, op_b, op_rd, op_rd_en,
      input  op_ready,
      input  wb_valid, wb_address, wb_data,
      output wb_ready,
      output pending_count, wb_err
   );

   modport master (
      output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_rd_en,
      input  issue_ready,
      input  rf_read_address_1, rf_read_address_2, rf_write_enable,
      input  rf_write_address, rf_data_in,
      output rf_data_out1, rf_data_out2,
      input  op_valid, op_a, op_b, op_rd, op_rd_en,
      output op_ready,
      output wb_valid, wb_address, wb_data,
      input  wb_ready,
      input  pending_count, wb_err
   );

endinterface

// File: rtl/regfile_scoreboard.sv
// Busy bit per register: set on issue, cleared on writeback commit, with
// hazard lookup for three indices and a popcount of outstanding writes.
module regfile_scoreboard
   import regfile_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       set_en,
   input  reg_addr_t  set_addr,
   input  logic       clr_en,
   input  reg_addr_t  clr_addr,
   input  reg_addr_t  rs1,
   input  reg_addr_t  rs2,
   input  reg_addr_t  rd,
   input  logic       rd_en,
   output logic       hazard,
   output logic       clr_busy,
   output reg_count_t pending_count
);

   logic [NUM_REGS-1:0] busy_reg;
   logic [NUM_REGS-1:0] busy_next;

   // A set on the same edge as a clear of the same bit wins.
   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
         assign busy_next[gi] = (set_en && set_addr == reg_addr_t'(gi)) |
                                (busy_reg[gi] & ~(clr_en && clr_addr == reg_addr_t'(gi)));
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_reg <= '0;
      end else begin
         busy_reg <= busy_next;
      end
   end

   assign hazard   = busy_reg[rs1] | busy_reg[rs2] | (rd_en & busy_reg[rd]);
   assign clr_busy = busy_reg[clr_addr];

   always_comb begin
      pending_count = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         pending_count = pending_count + reg_count_t'(busy_reg[i]);
      end
   end

endmodule

// File: rtl/regfile_access_controller.sv
// Client-side controller for a dual-port register file: operand fetch with
// scoreboard stalls and a one-cycle writeback buffer in front of the write port.
module regfile_access_controller
   import regfile_pkg::*;
(
   input logic                         clk,
   input logic                         reset,
   regfile_access_controller_if.slave  bus
);

   logic      hazard;
   logic      clr_busy;
   logic      issue_accept;

   logic      op_valid_reg;
   reg_data_t op_a_reg;
   reg_data_t op_b_reg;
   reg_addr_t op_rd_reg;
   logic      op_rd_en_reg;

   logic      wb_buf_valid_reg;
   reg_addr_t wb_buf_addr_reg;
   reg_data_t wb_buf_data_reg;
   logic      wb_err_reg;

   assign bus.issue_ready = !hazard && (!op_valid_reg || bus.op_ready);
   assign issue_accept    = bus.issue_valid && bus.issue_ready;

   assign bus.rf_read_address_1 = bus.issue_rs1;
   assign bus.rf_read_address_2 = bus.issue_rs2;

   regfile_scoreboard u_scoreboard (
      .clk           (clk),
      .reset         (reset),
      .set_en        (issue_accept && bus.issue_rd_en),
      .set_addr      (bus.issue_rd),
      .clr_en        (wb_buf_valid_reg),
      .clr_addr      (wb_buf_addr_reg),
      .rs1           (bus.issue_rs1),
      .rs2           (bus.issue_rs2),
      .rd            (bus.issue_rd),
      .rd_en         (bus.issue_rd_en),
      .hazard        (hazard),
      .clr_busy      (clr_busy),
      .pending_count (bus.pending_count)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_valid_reg <= 1'b0;
         op_a_reg     <= '0;
         op_b_reg     <= '0;
         op_rd_reg    <= '0;
         op_rd_en_reg <= 1'b0;
      end else if (issue_accept) begin
         op_valid_reg <= 1'b1;
         op_a_reg     <= bus.rf_data_out1;
         op_b_reg     <= bus.rf_data_out2;
         op_rd_reg    <= bus.issue_rd;
         op_rd_en_reg <= bus.issue_rd_en;
      end else if (bus.op_ready) begin
         op_valid_reg <= 1'b0;
      end
   end

   // The buffered entry commits on the edge after capture; committing to a
   // register nobody is waiting on flags a protocol error but still writes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wb_buf_valid_reg <= 1'b0;
         wb_buf_addr_reg  <= '0;
         wb_buf_data_reg  <= '0;
         wb_err_reg       <= 1'b0;
      end else begin
         wb_buf_valid_reg <= bus.wb_valid;
         if (bus.wb_valid) begin
            wb_buf_addr_reg <= bus.wb_address;
            wb_buf_data_reg <= bus.wb_data;
         end
         if (wb_buf_valid_reg && !clr_busy) begin
            wb_err_reg <= 1'b1;
         end
      end
   end

   assign bus.wb_ready         = !reset;
   assign bus.rf_write_enable  = wb_buf_valid_reg;
   assign bus.rf_write_address = wb_buf_addr_reg;
   assign bus.rf_data_in       = wb_buf_data_reg;

   assign bus.op_valid = op_valid_reg;
   assign bus.op_a     = op_a_reg;
   assign bus.op_b     = op_b_reg;
   assign bus.op_rd    = op_rd_reg;
   assign bus.op_rd_en = op_rd_en_reg;
   assign bus.wb_err   = wb_err_reg;

endmodule
